// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and high-time clamp for the clock divider
package clk_div_pkg;

    localparam int DEF_CNT_W = 28;
    localparam int MIN_DIV   = 2;
    localparam int DEF_DIV   = 25;
    localparam int DEF_HIGH  = 12;

    typedef logic [31:0] cnt_t;

    // div must already be at least MIN_DIV; result lies in [1, div-1] so the output always toggles
    function automatic cnt_t clamp_high(input cnt_t div, input cnt_t high);
        if (high == '0) begin
            return cnt_t'(1);
        end else if (high >= div) begin
            return div - cnt_t'(1);
        end else begin
            return high;
        end
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// rtl/clk_div_channel.sv - one divider channel with shadowed divisor/high-time
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int DEFAULT_DIV  = DEF_DIV,
    parameter int DEFAULT_HIGH = DEF_HIGH
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [CNT_W-1:0] div_value,
    input  logic [CNT_W-1:0] high_value,
    input  logic             sync_restart,
    output logic             clock_out,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] active_div;
    logic [CNT_W-1:0] active_high;
    logic [CNT_W-1:0] shadow_div;
    logic [CNT_W-1:0] shadow_high;
    logic [CNT_W-1:0] eff_div;
    logic [CNT_W-1:0] eff_high;
    logic             wrap;
    logic             apply;

    always_comb begin
        eff_div  = (active_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : active_div;
        eff_high = CNT_W'(clamp_high(cnt_t'(eff_div), cnt_t'(active_high)));
        wrap     = (counter == eff_div - CNT_W'(1));
        apply    = !enable || sync_restart || wrap;
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            counter     <= '0;
            clock_out   <= 1'b0;
            tick        <= 1'b0;
            pending     <= 1'b0;
            active_div  <= CNT_W'(DEFAULT_DIV);
            active_high <= CNT_W'(DEFAULT_HIGH);
            shadow_div  <= '0;
            shadow_high <= '0;
        end else begin
            if (pending && apply) begin
                active_div  <= shadow_div;
                active_high <= shadow_high;
                pending     <= 1'b0;
            end
            // a load on an apply edge is captured after the old shadow moves, so it stays pending
            if (load) begin
                shadow_div  <= div_value;
                shadow_high <= high_value;
                pending     <= 1'b1;
            end

            if (!enable) begin
                counter   <= '0;
                clock_out <= 1'b0;
                tick      <= 1'b0;
            end else if (sync_restart) begin
                counter   <= '0;
                clock_out <= 1'b1;
                tick      <= 1'b1;
            end else if (wrap) begin
                counter   <= '0;
                clock_out <= (counter < eff_high);
                tick      <= 1'b1;
            end else begin
                counter   <= counter + CNT_W'(1);
                clock_out <= (counter < eff_high);
                tick      <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider with common restart
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int DEFAULT_DIV  = DEF_DIV,
    parameter int DEFAULT_HIGH = DEF_HIGH
) (
    input  logic                    clock_in,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*CNT_W-1:0] divisor,
    input  logic [NUM_CH*CNT_W-1:0] high_time,
    input  logic                    sync_restart,
    output logic [NUM_CH-1:0]       clock_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       pending
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV),
            .DEFAULT_HIGH(DEFAULT_HIGH)
        ) u_ch (
            .clock_in    (clock_in),
            .reset       (reset),
            .enable      (enable[i]),
            .load        (load[i]),
            .div_value   (divisor[i*CNT_W +: CNT_W]),
            .high_value  (high_time[i*CNT_W +: CNT_W]),
            .sync_restart(sync_restart),
            .clock_out   (clock_out[i]),
            .tick        (tick[i]),
            .pending     (pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed self-checking bench for clk_div_multi
module tb_clk_div_multi;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 28;

    logic                    clock_in = 1'b0;
    logic                    reset = 1'b1;
    logic [NUM_CH-1:0]       enable = '0;
    logic [NUM_CH-1:0]       load = '0;
    logic [NUM_CH*CNT_W-1:0] divisor = '0;
    logic [NUM_CH*CNT_W-1:0] high_time = '0;
    logic                    sync_restart = 1'b0;
    logic [NUM_CH-1:0]       clock_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       pending;

    int errors = 0;
    int checks = 0;

    clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(25), .DEFAULT_HIGH(12)) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .divisor     (divisor),
        .high_time   (high_time),
        .sync_restart(sync_restart),
        .clock_out   (clock_out),
        .tick        (tick),
        .pending     (pending)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        int ch;
        int div;
        int high;
        int ed;
        int eh;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int k, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%b want=%b", name, k, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock_in);
        @(negedge clock_in);
    endtask

    function automatic logic exp_clk(input int k, input int off, input int ed, input int eh);
        return ((k - off - 1) % ed) < eh;
    endfunction

    function automatic logic exp_tick(input int k, input int off, input int ed);
        return ((k - off) % ed) == 0;
    endfunction

    task automatic set_slice(input int ch, input int dv, input int hv);
        divisor[ch*CNT_W +: CNT_W]   = CNT_W'(dv);
        high_time[ch*CNT_W +: CNT_W] = CNT_W'(hv);
    endtask

    initial begin
        int off, ed, eh;
        vecs[0] = '{0, 25, 12, 25, 12};
        vecs[1] = '{0, 10,  3, 10,  3};
        vecs[2] = '{1,  1,  0,  2,  1};
        vecs[3] = '{0,  0,  5,  2,  1};
        vecs[4] = '{1,  5,  9,  5,  4};
        vecs[5] = '{0,  7,  0,  7,  1};
        vecs[6] = '{1,  3,  2,  3,  2};

        // reset state
        cyc();
        cyc();
        chk("rst_clk", 0, |clock_out, 1'b0);
        chk("rst_tick", 0, |tick, 1'b0);
        chk("rst_pend", 0, |pending, 1'b0);

        // default run on both channels, with ch0 reprogrammed mid-period and on a wrap
        reset  = 1'b0;
        enable = 2'b11;
        for (int k = 1; k <= 60; k++) begin
            load = '0;
            if (k == 5)  begin load[0] = 1'b1; set_slice(0, 10, 3); end
            if (k == 27) begin load[0] = 1'b1; set_slice(0, 4, 2);  end
            if (k == 35) begin load[0] = 1'b1; set_slice(0, 6, 1);  end
            cyc();
            if (k <= 25)      begin off = 0;  ed = 25; eh = 12; end
            else if (k <= 35) begin off = 25; ed = 10; eh = 3;  end
            else if (k <= 39) begin off = 35; ed = 4;  eh = 2;  end
            else              begin off = 39; ed = 6;  eh = 1;  end
            chk("seq_ch0_clk", k, clock_out[0], exp_clk(k, off, ed, eh));
            chk("seq_ch0_tick", k, tick[0], exp_tick(k, off, ed));
            chk("seq_ch0_pend", k, pending[0], (k >= 5 && k <= 24) || (k >= 27 && k <= 38));
            chk("seq_ch1_clk", k, clock_out[1], exp_clk(k, 0, 25, 12));
            chk("seq_ch1_tick", k, tick[1], exp_tick(k, 0, 25));
            chk("seq_ch1_pend", k, pending[1], 1'b0);
        end
        load = '0;

        // table: program while disabled, run, then disable mid-period
        for (int v = 0; v < 7; v++) begin
            enable = '0;
            load[vecs[v].ch] = 1'b1;
            set_slice(vecs[v].ch, vecs[v].div, vecs[v].high);
            cyc();
            load = '0;
            chk("tbl_pend_set", v, pending[vecs[v].ch], 1'b1);
            cyc();
            chk("tbl_pend_clr", v, pending[vecs[v].ch], 1'b0);
            enable[vecs[v].ch] = 1'b1;
            for (int k = 1; k <= 2 * vecs[v].ed + 2; k++) begin
                cyc();
                chk("tbl_clk", k, clock_out[vecs[v].ch], exp_clk(k, 0, vecs[v].ed, vecs[v].eh));
                chk("tbl_tick", k, tick[vecs[v].ch], exp_tick(k, 0, vecs[v].ed));
            end
            enable = '0;
            cyc();
            chk("tbl_dis_clk", v, clock_out[vecs[v].ch], 1'b0);
            chk("tbl_dis_tick", v, tick[vecs[v].ch], 1'b0);
        end

        // common restart: ch0 div 10 / high 3, ch1 div 25 / high 12
        load = 2'b11;
        set_slice(0, 10, 3);
        set_slice(1, 25, 12);
        cyc();
        load = '0;
        cyc();
        enable = 2'b11;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            chk("pre_ch0_clk", k, clock_out[0], exp_clk(k, 0, 10, 3));
            chk("pre_ch1_clk", k, clock_out[1], exp_clk(k, 0, 25, 12));
        end
        sync_restart = 1'b1;
        cyc();
        sync_restart = 1'b0;
        chk("sync_clk", 0, &clock_out, 1'b1);
        chk("sync_tick", 0, &tick, 1'b1);
        for (int j = 1; j <= 30; j++) begin
            cyc();
            chk("sync_ch0_clk", j, clock_out[0], exp_clk(j, 0, 10, 3));
            chk("sync_ch0_tick", j, tick[0], exp_tick(j, 0, 10));
            chk("sync_ch1_clk", j, clock_out[1], exp_clk(j, 0, 25, 12));
            chk("sync_ch1_tick", j, tick[1], exp_tick(j, 0, 25));
        end

        // async reset during ch0 high phase with a pending shadow
        load[0] = 1'b1;
        set_slice(0, 8, 4);
        cyc();
        load = '0;
        chk("ar_pre_clk", 0, clock_out[0], 1'b1);
        chk("ar_pre_pend", 0, pending[0], 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("ar_clk", 0, |clock_out, 1'b0);
        chk("ar_tick", 0, |tick, 1'b0);
        chk("ar_pend", 0, |pending, 1'b0);
        @(negedge clock_in);
        reset = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            chk("post_ch0_clk", k, clock_out[0], exp_clk(k, 0, 25, 12));
            chk("post_ch0_tick", k, tick[0], exp_tick(k, 0, 25));
            chk("post_ch1_clk", k, clock_out[1], exp_clk(k, 0, 25, 12));
            chk("post_pend", k, |pending, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
